// File: rtl/bk_pkg.sv
// bk_pkg: shared constants, types and helpers for the Brent-Kung operand stage.
//   BK_WIDTH   - default operand width of the adder netlist
//   bk_sum_t   - adder result type (BK_WIDTH+1 bits, MSB is carry-out)
//   interleave - builds the adder input bus: bus[2i]=a[i], bus[2i+1]=b[i]
package bk_pkg;

  localparam int BK_WIDTH = 12;

  typedef logic [BK_WIDTH:0] bk_sum_t;

  function automatic logic [2*BK_WIDTH-1:0] interleave(
    input logic [BK_WIDTH-1:0] a,
    input logic [BK_WIDTH-1:0] b
  );
    logic [2*BK_WIDTH-1:0] bus;
    bus = {(2*BK_WIDTH){1'b0}};
    for (int i = 0; i < BK_WIDTH; i++) begin
      bus[2*i]   = a[i];
      bus[2*i+1] = b[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/bk_sync_fifo.sv
// bk_sync_fifo: single-clock FIFO with synchronous active-high reset.
// Ports:
//   clk, rst     - clock (rising edge) and synchronous reset
//   push, wdata  - write request and data (ignored while full)
//   pop          - read request (ignored while empty); rdata shows the head
//   full, empty  - occupancy flags
//   level        - number of entries in use (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module bk_sync_fifo
  import bk_pkg::*;
#(
  parameter int DW    = 2 * BK_WIDTH,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == LW'(0));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; push and pop together leave the level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PW'(0);
      rd_ptr <= PW'(0);
      level  <= LW'(0);
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/bk_operand_stage.sv
// bk_operand_stage: registered wrapper around an external combinational
// Brent-Kung adder. FIFO -> S1 (operand register driving adder_in) ->
// S2 (result register), with valid/ready handshakes on both sides.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid/in_ready   - operand handshake, in_a/in_b operands
//   adder_in            - registered interleaved bus to the adder
//   adder_out           - combinational adder result (MSB = carry-out)
//   out_valid/out_ready - result handshake, out_sum registered result
//   fifo_level          - input FIFO occupancy
//   carry_count         - saturating count of delivered results with carry set
module bk_operand_stage
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [2*WIDTH-1:0]       adder_in,
  input  logic [WIDTH:0]           adder_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH:0]           out_sum,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         carry_count
);

  localparam int DW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          s1_valid;
  logic          s1_load;
  logic          s2_load;
  logic [DW-1:0] head;
  logic [DW-1:0] head_bus;

  // in_ready deliberately ignores out_ready and a same-cycle pop, so a full
  // FIFO always refuses; this keeps the ready path short.
  assign in_ready = !rst && !fifo_full;
  assign push     = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign s1_load  = !fifo_empty && (!s1_valid || s2_load);

  bk_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (s1_load),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // FIFO entries hold {a, b}; spread them into the adder's interleaved order.
  if (WIDTH == BK_WIDTH) begin : g_pkg_interleave
    assign head_bus = interleave(head[DW-1:WIDTH], head[WIDTH-1:0]);
  end else begin : g_generic_interleave
    // Same bit mapping as the package helper, for non-default widths.
    always_comb begin
      head_bus = {DW{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        head_bus[2*i]   = head[WIDTH+i];
        head_bus[2*i+1] = head[i];
      end
    end
  end

  // S1: operand register; adder_in keeps its last value when S1 empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      adder_in <= {DW{1'b0}};
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      adder_in <= head_bus;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s1_valid;
    end
  end

  // S2: result register; holds out_sum while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= {(WIDTH+1){1'b0}};
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_sum   <= adder_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Carry-out counter: counts delivered results only, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_count <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready && out_sum[WIDTH] && (carry_count != CNT_MAX)) begin
      carry_count <= carry_count + CNT_W'(1);
    end else begin
      carry_count <= carry_count;
    end
  end

endmodule

// File: tb/tb_bk_operand_stage.sv
// Self-checking bench for bk_operand_stage with a behavioural adder model.
module tb_bk_operand_stage;
  import bk_pkg::*;

  localparam int W  = 12;
  localparam int D  = 2;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic [2*W-1:0]    adder_in;
  logic [W:0]        adder_out;
  logic              out_valid;
  logic              out_ready;
  logic [W:0]        out_sum;
  logic [$clog2(D):0] fifo_level;
  logic [CW-1:0]     carry_count;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  bk_sum_t sb_q[$];

  bk_operand_stage #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .adder_in    (adder_in),
    .adder_out   (adder_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .fifo_level  (fifo_level),
    .carry_count (carry_count)
  );

  always #5 clk = ~clk;

  // Reference adder: de-interleave the bus and add.
  logic [W-1:0] mdl_a;
  logic [W-1:0] mdl_b;
  for (genvar i = 0; i < W; i++) begin : g_deint
    assign mdl_a[i] = adder_in[2*i];
    assign mdl_b[i] = adder_in[2*i+1];
  end
  assign adder_out = {1'b0, mdl_a} + {1'b0, mdl_b};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable between edges, so the negedge sees exactly
  // what the following rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(bk_sum_t'({1'b0, in_a} + {1'b0, in_b}));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_out", 32'(out_sum), 32'hFFFF_FFFF);
        end else begin
          check("sb_sum", 32'(out_sum), 32'(sb_q.pop_front()));
          delivered++;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_adder_in", 32'(adder_in), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_carry", 32'(carry_count), 32'd0);
    check("rst_in_ready_after", 32'(in_ready), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(sb_q.size() != 0 || out_valid), 32'd0);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] bus;
    logic [W:0]     sum;
    logic [CW-1:0]  carry;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int base;
    int n;
    int c;
    logic acc;
    logic [W-1:0] bp_a[4];
    logic [W-1:0] bp_b[4];

    tbl[0] = '{12'hFFF, 12'h001, 24'h555557, 13'h1000, 4'd1};
    tbl[1] = '{12'hA5A, 12'h000, 24'h441144, 13'h0A5A, 4'd0};
    tbl[2] = '{12'h000, 12'hFFF, 24'hAAAAAA, 13'h0FFF, 4'd0};
    tbl[3] = '{12'h123, 12'h456, 24'h21262D, 13'h0579, 4'd0};
    tbl[4] = '{12'hFFF, 12'hFFF, 24'hFFFFFF, 13'h1FFE, 4'd1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 12'h000;
    in_b = 12'h000;
    out_ready = 1'b1;
    step();

    // Single ops: latency, interleave, sum and carry counting.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_a = tbl[i].a;
      in_b = tbl[i].b;
      step();
      in_valid = 1'b0;
      check("single_level_k", 32'(fifo_level), 32'd1);
      check("single_valid_k", 32'(out_valid), 32'd0);
      step();
      check("single_adder_in", 32'(adder_in), 32'(tbl[i].bus));
      check("single_level_k1", 32'(fifo_level), 32'd0);
      check("single_valid_k1", 32'(out_valid), 32'd0);
      step();
      check("single_valid_k2", 32'(out_valid), 32'd1);
      check("single_sum", 32'(out_sum), 32'(tbl[i].sum));
      step();
      check("single_carry", 32'(carry_count), 32'(tbl[i].carry));
      check("single_valid_k3", 32'(out_valid), 32'd0);
    end

    // Streaming: four back-to-back pairs, one result per cycle.
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 12'h001; in_b = 12'h001; step();
    in_a = 12'h002; in_b = 12'h002; step();
    in_a = 12'h800; in_b = 12'h800; step();
    check("stream_sum0", 32'(out_sum), 32'h002);
    check("stream_v0", 32'(out_valid), 32'd1);
    in_a = 12'h7FF; in_b = 12'h001; step();
    in_valid = 1'b0;
    check("stream_sum1", 32'(out_sum), 32'h004);
    step();
    check("stream_sum2", 32'(out_sum), 32'h1000);
    step();
    check("stream_sum3", 32'(out_sum), 32'h800);
    check("stream_v3", 32'(out_valid), 32'd1);
    step();
    check("stream_carry", 32'(carry_count), 32'd1);
    check("stream_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure: exactly DEPTH+2 accepts, then stall with a stable result.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = W'(i + 1);
      bp_b[i] = W'(16 * (i + 1));
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = bp_a[0];
    in_b = bp_b[0];
    n = 0;
    for (int k = 0; k < 8; k++) begin
      acc = in_ready;
      step();
      if (acc) begin
        n++;
        in_a = (n < 4) ? bp_a[n] : 12'h777;
        in_b = (n < 4) ? bp_b[n] : 12'h777;
      end
    end
    check("bp_accepts", 32'(n), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_level", 32'(fifo_level), 32'd2);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_sum_stable", 32'(out_sum), 32'(bp_a[0]) + 32'(bp_b[0]));
    base = delivered;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);
    check("bp_delivered", 32'(delivered - base), 32'd4);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Reset mid-flight: three carry-producing ops must never emerge.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 12'hFFF;
    in_b = 12'hFFF;
    for (int k = 0; k < 3; k++) step();
    in_valid = 1'b0;
    check("mid_level", 32'(fifo_level), 32'd1);
    out_ready = 1'b1;
    do_reset();
    c = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) c++;
      step();
    end
    check("mid_no_stale", 32'(c), 32'd0);
    check("mid_carry", 32'(carry_count), 32'd0);
    in_valid = 1'b1;
    in_a = 12'h321;
    in_b = 12'h123;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_resume_sum", 32'(out_sum), 32'h444);
    drain(10);

    // Saturation: 17 carry results on a 4-bit counter.
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 12'hFFF;
    in_b = 12'hFFF;
    base = delivered;
    n = 0;
    c = 0;
    while (n < 17 && c < 60) begin
      acc = in_ready;
      step();
      c++;
      if (acc) n++;
    end
    in_valid = 1'b0;
    check("sat_sent", 32'(n), 32'd17);
    drain(20);
    check("sat_delivered", 32'(delivered - base), 32'd17);
    check("sat_carry", 32'(carry_count), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bk_operand_stage.md
# bk_operand_stage

Registered operand/result stage that wraps the 12-bit combinational Brent-Kung adder netlist. It accepts operand pairs over a valid/ready handshake, buffers them in a small FIFO, drives the adder's interleaved 24-bit input bus from a register, and captures the 13-bit adder result into an output register with its own valid/ready handshake. It sits directly upstream and downstream of the adder, so each mapped netlist is timed register-to-register, with full backpressure.

## Interface
- WIDTH, 12: operand width. The adder bus is 2*WIDTH in and WIDTH+1 out.
- DEPTH, 2: input FIFO depth. Must be a power of two, at least 2.
- CNT_W, 16: width of the carry-out counter.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept an operand pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- adder_in  out  2*WIDTH  registered interleaved bus: adder_in[2i]=a[i], adder_in[2i+1]=b[i].
- adder_out  in  WIDTH+1  combinational adder result. Bit WIDTH is carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH+1  registered result.
- fifo_level  out  clog2(DEPTH)+1  number of FIFO entries in use.
- carry_count  out  CNT_W  saturating count of delivered results with out_sum[WIDTH]=1.

## Operation
- **Pipeline.** The stage is FIFO (DEPTH entries), then S1 (operand register, drives adder_in, flag s1_valid), then S2 (result register, out_sum/out_valid).
- **Input handshake.** An operand pair is accepted when in_valid and in_ready are both 1 at a rising edge.
  - in_ready = !rst && fifo_level < DEPTH.
  - in_ready does not depend on out_ready. A full FIFO refuses a push even in a cycle where it also pops.
- **S2 load.** s2_load = s1_valid && (!out_valid || out_ready). S2 captures adder_out.
- **S1 load.** s1_load = fifo_nonempty && (!s1_valid || s2_load). S1 pops the FIFO head and stores it interleaved.
  - If s1_valid falls and nothing is loaded, adder_in holds its last value.
- **Output handshake.**
  - out_valid deasserts on out_ready only if no new result is loaded in the same cycle.
  - While out_valid && !out_ready, out_sum is held stable.
- **Ordering.** Results leave strictly in input order. Nothing is dropped or duplicated.
- **Capacity.** DEPTH+2 transactions in flight, i.e. 4 at default.
- **Arithmetic.** The block does no arithmetic of its own; out_sum is adder_out captured verbatim.
- **Carry counter.** carry_count increments by 1 on every output handshake where out_sum[WIDTH]=1. It saturates at 2^CNT_W-1 and never wraps.
- **FIFO pointers.** Pointers wrap modulo DEPTH. fifo_level goes up on push-only, down on pop-only, and is unchanged on push+pop.

## Timing
- **Reset values.** While rst is 1 and on the first cycle after it falls:
  - in_ready=0 during rst, 1 from the first cycle after.
  - out_valid=0, out_sum=0, adder_in=0, fifo_level=0, carry_count=0.
  - s1_valid=0 and the FIFO pointers are 0.
- **Reset mid-operation.** Reset discards all in-flight transactions at the reset edge, with no partial outputs. A handshake in the reset cycle is ignored.
- **Latency.** A pair accepted at edge k:
  - is written to the FIFO at k;
  - is in S1, driving adder_in, after k+1;
  - shows out_valid=1 with its sum after k+2, assuming no backpressure.
- **Throughput.** One result per cycle with out_ready held high.
- **Adder path.** The adder sees a full clock period from adder_in to adder_out.

## Structure
- **Package bk_pkg:**
  - default WIDTH constant;
  - function interleave(a,b) returning the 2*WIDTH bus;
  - typedef for the WIDTH+1 result.
- **Sub-module bk_sync_fifo:** synchronous FIFO parameterised by data width and DEPTH, with push/pop/full/empty/level outputs and synchronous reset. It holds a and b concatenated (2*WIDTH bits).
- **Top level:** S1/S2 control, interleave, and the carry counter. The adder is not instantiated inside this block; the testbench connects a reference model or the netlist to adder_in/adder_out.

## Test plan
- **Single op.** in_a=0xFFF, in_b=0x001 accepted at edge k, out_ready=1. Expect out_valid after k+2, out_sum=0x1000, carry_count=1.
- **Interleave.** in_a=0xA5A, in_b=0x000. Expect adder_in odd bits all 0 and adder_in[2i]=bit i of 0xA5A. Then repeat with in_a=0, in_b=0xFFF: expect adder_in=0xAAAAAA.
- **Streaming.** Four back-to-back pairs (1+1, 2+2, 0x800+0x800, 0x7FF+0x001) with out_ready=1. Expect sums 0x002, 0x004, 0x1000, 0x800 on consecutive cycles, in order, and carry_count=1.
- **Backpressure.** out_ready=0 with in_valid held. Expect exactly 4 accepts, then in_ready=0 and fifo_level=2, with out_sum stable. Raise out_ready: all 4 results drain in order and in_ready returns to 1.
- **Reset mid-flight.** With 3 transactions in flight, assert rst for 1 cycle. Expect all outputs at their reset values, no stale result ever appearing, and normal operation resuming.
- **Saturation (CNT_W=4).** Deliver 17 results with carry set (0xFFF+0xFFF). Expect carry_count to reach 15 and stay at 15, with out_sum=0x1FFE each time.
